// File: rtl/serial_signed_div_by_power_of_2.sv
// Serial signed divide by 2^k: arithmetic right shift, one bit per clock.
// SERIAL_SIGNED_DIV_ROUND_ZERO_EN adds a ROUND state for truncation toward zero.
module serial_signed_div_by_power_of_2 #(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [W-1:0] in_shamt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_acc;
    logic [W-1:0] r_cnt;
    logic         r_sticky;
    logic         w_last;

    assign w_last = (r_cnt == {{(W-1){1'b0}}, 1'b1});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = (in_shamt != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
`ifdef SERIAL_SIGNED_DIV_ROUND_ZERO_EN
                    w_state_nxt = S_ROUND;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef SERIAL_SIGNED_DIV_ROUND_ZERO_EN
            S_ROUND: begin
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
        out_data  = r_acc;
    end

    // sticky collects every bit shifted out, so ROUND knows if anything was lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_acc    <= in_data;
                        r_cnt    <= in_shamt;
                        r_sticky <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_acc    <= {r_acc[N-1], r_acc[N-1:1]};
                    r_sticky <= r_sticky | r_acc[0];
                    r_cnt    <= r_cnt - {{(W-1){1'b0}}, 1'b1};
                end
`ifdef SERIAL_SIGNED_DIV_ROUND_ZERO_EN
                S_ROUND: begin
                    if (r_acc[N-1] && r_sticky) begin
                        r_acc <= r_acc + {{(N-1){1'b0}}, 1'b1};
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule
